// File: rtl/hmac_tag_checker.sv
// hmac_tag_checker
//   Feeds message blocks from a host to an external HMAC engine, captures the
//   final MAC and compares it against a preloaded expected tag in constant
//   time (always CMP_WORDS compare cycles, no early exit on a difference).
//
// Ports
//   clock, reset          clock; asynchronous active-high reset
//   tag_load, tag_in      load expected tag (IDLE, first block only)
//   msg_valid/msg_ready   host block handshake; msg_block, msg_len, msg_last
//   key_valid             key present; an accept without it reports error
//   done, match, error    one-cycle result strobe with qualified flags
//   hmac_start/init/final engine control; hmac_block, hmac_len block to engine
//   hmac_ready/valid/busy engine status; hmac_mac engine result
//   state_dbg             current FSM state (IDLE=0 .. RESULT=5)
//
// Handshake: a host block transfers on a rising edge where msg_valid and
// msg_ready are both 1. msg_valid may be held while msg_ready is low; the
// block, len and last inputs are only sampled on the transfer edge.
module hmac_tag_checker #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CMP_WORDS      = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tag_load,
  input  logic [255:0] tag_in,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [511:0] msg_block,
  input  logic [9:0]   msg_len,
  input  logic         msg_last,
  output logic         done,
  output logic         match,
  output logic         error,
  input  logic         key_valid,
  output logic         hmac_start,
  output logic         hmac_init,
  output logic         hmac_final,
  output logic [511:0] hmac_block,
  output logic [9:0]   hmac_len,
  input  logic         hmac_ready,
  input  logic         hmac_valid,
  input  logic         hmac_busy,
  input  logic [255:0] hmac_mac,
  output logic [2:0]   state_dbg
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WIDX_W = (CMP_WORDS > 1) ? $clog2(CMP_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ISSUE       = 3'd1,
    S_WAIT_ACCEPT = 3'd2,
    S_WAIT_DONE   = 3'd3,
    S_COMPARE     = 3'd4,
    S_RESULT      = 3'd5
  } state_t;

  state_t              state, state_nx;
  logic                first_blk, diff, err_flag;
  logic [CNT_W-1:0]    cnt;
  logic [WIDX_W-1:0]   widx;
  logic [255:0]        tag_reg, mac_reg;
  logic [511:0]        blk_reg;
  logic [9:0]          len_reg;
  logic                init_reg, last_reg;
  logic                accept, timed_out, last_word, word_diff, wait_state;

  // reset gates msg_ready so nothing is accepted while the block is held.
  assign msg_ready  = (state == S_IDLE) & hmac_ready & ~reset;
  assign accept     = msg_valid & msg_ready;
  // Terminal count is one below the limit so that exactly TIMEOUT_CYCLES
  // wait cycles elapse before RESULT.
  assign timed_out  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign last_word  = (widx == WIDX_W'(CMP_WORDS - 1));
  assign word_diff  = |(mac_reg[{widx, 5'd0} +: 32] ^ tag_reg[{widx, 5'd0} +: 32]);
  assign wait_state = (state == S_WAIT_ACCEPT) | (state == S_WAIT_DONE);

  // Engine-facing data comes straight from the holding registers, which only
  // change on a host accept, so it is stable for the whole engine exchange.
  assign hmac_block = blk_reg;
  assign hmac_len   = len_reg;
  assign hmac_init  = init_reg;
  assign hmac_final = last_reg;
  assign state_dbg  = state;

  always_comb begin
    state_nx   = state;
    hmac_start = 1'b0;
    done       = 1'b0;
    match      = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = key_valid ? S_ISSUE : S_RESULT;
      end
      S_ISSUE: begin
        hmac_start = 1'b1;
        state_nx   = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (hmac_busy)      state_nx = S_WAIT_DONE;
        else if (timed_out) state_nx = S_RESULT;
      end
      S_WAIT_DONE: begin
        // A non-last block finishes on engine ready; a stray hmac_valid there
        // is deliberately ignored.
        if (last_reg && hmac_valid)       state_nx = S_COMPARE;
        else if (!last_reg && hmac_ready) state_nx = S_IDLE;
        else if (timed_out)               state_nx = S_RESULT;
      end
      S_COMPARE: begin
        if (last_word) state_nx = S_RESULT;
      end
      S_RESULT: begin
        done     = 1'b1;
        match    = ~diff & ~err_flag;
        error    = err_flag;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      first_blk <= 1'b1;
      diff      <= 1'b0;
      err_flag  <= 1'b0;
      cnt       <= '0;
      widx      <= '0;
      tag_reg   <= '0;
      mac_reg   <= '0;
      blk_reg   <= '0;
      len_reg   <= '0;
      init_reg  <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state <= state_nx;
      if (wait_state && state_nx == S_RESULT) err_flag <= 1'b1;
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          widx <= '0;
          if (tag_load && first_blk) tag_reg <= tag_in;
          if (accept) begin
            if (key_valid) begin
              blk_reg  <= msg_block;
              len_reg  <= msg_len;
              last_reg <= msg_last;
              init_reg <= first_blk;
            end else begin
              err_flag <= 1'b1;
            end
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT_ACCEPT: begin
          if (hmac_busy) cnt <= '0;
          else           cnt <= cnt + CNT_W'(1);
        end
        S_WAIT_DONE: begin
          cnt <= cnt + CNT_W'(1);
          if (!last_reg && hmac_ready) first_blk <= 1'b0;
          if (last_reg && hmac_valid)  mac_reg   <= hmac_mac;
        end
        S_COMPARE: begin
          diff <= diff | word_diff;
          widx <= widx + WIDX_W'(1);
        end
        S_RESULT: begin
          first_blk <= 1'b1;
          diff      <= 1'b0;
          err_flag  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_tag_checker.sv
// Testbench for hmac_tag_checker: random multi-block messages against a
// behavioural engine stub; results checked through an expected-result queue.
module tb_hmac_tag_checker;

  localparam int TO = 15;
  localparam int CW = 8;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic         tag_load, msg_valid, msg_last, key_valid;
  logic [255:0] tag_in;
  logic [511:0] msg_block;
  logic [9:0]   msg_len;
  logic         msg_ready, done, match, error;
  logic         hmac_start, hmac_init, hmac_final;
  logic [511:0] hmac_block;
  logic [9:0]   hmac_len;
  logic         hmac_ready, hmac_valid, hmac_busy;
  logic [255:0] hmac_mac;
  logic [2:0]   state_dbg;

  hmac_tag_checker #(.TIMEOUT_CYCLES(TO), .CMP_WORDS(CW)) dut (
    .clock(clock), .reset(reset), .tag_load(tag_load), .tag_in(tag_in),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_block(msg_block),
    .msg_len(msg_len), .msg_last(msg_last), .done(done), .match(match),
    .error(error), .key_valid(key_valid), .hmac_start(hmac_start),
    .hmac_init(hmac_init), .hmac_final(hmac_final), .hmac_block(hmac_block),
    .hmac_len(hmac_len), .hmac_ready(hmac_ready), .hmac_valid(hmac_valid),
    .hmac_busy(hmac_busy), .hmac_mac(hmac_mac), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  // exp_q entry: {latency kind[1:0], match, error}
  //   kind 1: done = valid cycle + CW + 1; 2: done 1..2 cycles after accept;
  //   kind 3: done = start cycle + TO + 1 (timeout)
  logic [3:0] exp_q[$];
  logic [1:0] ctl_q[$];   // expected {init, final} per hmac_start
  int  valid_cycle = 0;
  int  start_cycle = 0;
  int  accept_cycle = 0;
  bit  stub_mute = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Toy engine: running 256-bit digest over blocks and byte counts.
  function automatic logic [255:0] mix(input logic [255:0] a, input logic [511:0] b,
                                       input logic [9:0] l);
    return {a[254:0], a[255]} ^ b[511:256] ^ b[255:0] ^ {246'd0, l};
  endfunction

  // ---------------- engine stub ----------------
  initial begin : engine_stub
    logic [1:0]   c;
    logic [511:0] b;
    logic [9:0]   l;
    logic         fin;
    logic [255:0] acc;
    hmac_ready = 1'b1; hmac_busy = 1'b0; hmac_valid = 1'b0; hmac_mac = '0; acc = '0;
    forever begin
      @(negedge clock);
      if (!reset && hmac_start) begin
        start_cycle = cyc;
        if (ctl_q.size() == 0) check("unexpected_hmac_start", 1, 0);
        else begin
          c = ctl_q.pop_front();
          check("init_final", {hmac_init, hmac_final}, c);
        end
        b = hmac_block; l = hmac_len; fin = hmac_final;
        if (hmac_init) acc = IV;
        acc = mix(acc, b, l);
        if (!stub_mute) begin
          repeat ($urandom_range(1, 4)) @(posedge clock);
          #1 hmac_busy = 1'b1; hmac_ready = 1'b0;
          @(posedge clock);
          #1 hmac_busy = 1'b0;
          repeat ($urandom_range(0, 5)) @(posedge clock);
          #1;
          check("block_stable", {hmac_block, 246'd0, hmac_len}, {b, 246'd0, l});
          if (fin) begin
            hmac_mac = acc; hmac_valid = 1'b1; valid_cycle = cyc;
            @(posedge clock);
            #1 hmac_valid = 1'b0; hmac_ready = 1'b1;
          end else begin
            if ($urandom_range(0, 1) == 1) begin
              hmac_mac = ~acc; hmac_valid = 1'b1;   // stray valid, must be ignored
              @(posedge clock);
              #1 hmac_valid = 1'b0;
            end
            hmac_ready = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [3:0] e;
    int d;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (match && error) check("match_and_error", {match, error}, 2'b10);
        if (!done) begin
          if (match || error) check("unqualified_flags", {match, error}, 2'b00);
        end else if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("match_error", {match, error}, e[1:0]);
          case (e[3:2])
            2'd1: check("latency_from_valid", cyc - valid_cycle, CW + 1);
            2'd2: begin
              d = cyc - accept_cycle;
              check("latency_key_error", (d >= 1 && d <= 2), 1);
            end
            2'd3: check("latency_timeout", cyc - start_cycle, TO + 1);
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_msg(input int nblk, input bit key, input int flip, input bit abort_cmp);
    logic [511:0] blks[3];
    logic [9:0]   lens[3];
    logic [255:0] acc, tag;
    int waited;
    for (int i = 0; i < nblk; i++) begin
      for (int w = 0; w < 16; w++) blks[i][w*32 +: 32] = $urandom();
      lens[i] = 10'($urandom_range(1, 64));
    end
    acc = IV;
    for (int i = 0; i < nblk; i++) acc = mix(acc, blks[i], lens[i]);
    tag = acc;
    if (flip >= 0) tag[flip] = ~tag[flip];
    @(posedge clock);
    #1 tag_load = 1'b1; tag_in = tag;
    @(posedge clock);
    #1 tag_load = 1'b0; tag_in = ~tag;
    for (int b = 0; b < nblk; b++) begin
      if (b > 0) begin   // tag_load past the first block must be ignored
        tag_load = 1'b1;
        @(posedge clock);
        #1 tag_load = 1'b0;
      end
      msg_valid = 1'b1; msg_block = blks[b]; msg_len = lens[b];
      msg_last = (b == nblk - 1); key_valid = key;
      waited = 0;
      forever begin
        @(negedge clock);
        if (msg_ready || waited > 200) break;
        waited++;
      end
      if (!msg_ready) begin
        check("msg_ready_timeout", 0, 1);
        msg_valid = 1'b0;
        return;
      end
      accept_cycle = cyc;
      if (!key) exp_q.push_back({2'd2, 2'b01});
      else begin
        ctl_q.push_back({b == 0, b == nblk - 1});
        if (b == nblk - 1)
          exp_q.push_back(stub_mute ? {2'd3, 2'b01} : {2'd1, flip < 0, 1'b0});
      end
      @(posedge clock);
      #1 msg_valid = 1'b0; msg_block = ~msg_block; msg_last = ~msg_last;
      @(negedge clock);
      check("ready_low_after_accept", msg_ready, 0);
      if (!key) break;
    end
    if (abort_cmp) begin
      waited = 0;
      while (state_dbg != 3'd4 && waited < 300) begin @(negedge clock); waited++; end
      check("reached_compare", state_dbg, 3'd4);
      #2 reset = 1'b1;
      #1;
      check("async_state", state_dbg, 3'd0);
      check("async_ready", msg_ready, 0);
      check("async_ctl", {done, match, error, hmac_start, hmac_init, hmac_final}, 6'd0);
      check("async_len", hmac_len, 10'd0);
      exp_q.delete();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);   // monitor flags any stray done here
    end else begin
      waited = 0;
      while (exp_q.size() != 0 && waited < 400) begin @(negedge clock); waited++; end
      if (exp_q.size() != 0) begin
        check("done_timeout", 0, 1);
        exp_q.delete();
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tag_load = 1'b0; tag_in = '0; msg_valid = 1'b0; msg_block = '0;
    msg_len = '0; msg_last = 1'b0; key_valid = 1'b0;
    #12;
    check("reset_state", state_dbg, 3'd0);
    check("reset_ready", msg_ready, 0);
    check("reset_ctl", {done, match, error, hmac_start, hmac_init, hmac_final}, 6'd0);
    check("reset_block", hmac_block, 512'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    send_msg(1, 1'b1, -1, 1'b0);                        // single block, match
    send_msg(1, 1'b1, 255, 1'b0);                       // bit 255 flipped
    send_msg(3, 1'b1, -1, 1'b0);                        // three blocks, match
    send_msg(3, 1'b1, int'($urandom_range(0, 255)), 1'b0);
    send_msg(1, 1'b0, -1, 1'b0);                        // key missing
    for (int n = 0; n < 12; n++)
      send_msg(int'($urandom_range(1, 3)), $urandom_range(0, 9) != 0,
               ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 255)), 1'b0);
    stub_mute = 1'b1;
    send_msg(1, 1'b1, -1, 1'b0);                        // engine never busy
    stub_mute = 1'b0;
    send_msg(2, 1'b1, -1, 1'b0);                        // recovers after timeout
    send_msg(1, 1'b1, -1, 1'b1);                        // reset during compare
    send_msg(1, 1'b1, -1, 1'b0);
    send_msg(1, 1'b1, 0, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    check("ctl_q_drained", ctl_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
